// File: rtl/nios_fprint_pkg.sv
// Shared state encoding, bus addresses and expected image fingerprint for the
// system-ID checker.
package nios_fprint_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ_ID = 3'd1,
      ST_LAT_ID = 3'd2,
      ST_REQ_TS = 3'd3,
      ST_LAT_TS = 3'd4,
      ST_FINISH = 3'd5
   } state_e;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   localparam logic [31:0] SYSID_EXPECTED_ID = 32'h0000_0000;
   localparam logic [31:0] SYSID_EXPECTED_TS = 32'h539F_2976;

   localparam int unsigned TMR_W = 8;

   // A down-counter loaded with n-1 reports zero on the n-th enabled cycle.
   function automatic logic [TMR_W-1:0] tmr_load_val(input int unsigned n);
      return (n == 0) ? '0 : TMR_W'(n - 1);
   endfunction

endpackage

// File: rtl/nios_fprint_rd_timer.sv
// Down-counter shared between read-latency and waitrequest-timeout tracking.
// Load wins over enable; the count saturates at zero and zero_o flags expiry.
module nios_fprint_rd_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/nios_fprint_sysid_checker.sv
// Avalon-MM read master: fetches system ID and build timestamp, compares them
// with the expected image; done lands 3+2*READ_LATENCY cycles after start when unstalled.
module nios_fprint_sysid_checker
   import nios_fprint_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = SYSID_EXPECTED_ID,
   parameter logic [31:0] EXPECTED_TS    = SYSID_EXPECTED_TS,
   parameter int unsigned READ_LATENCY   = 0,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        address,
   output logic        read,
   input  logic [31:0] readdata,
   input  logic        waitrequest,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam logic [TMR_W-1:0] TO_LOAD  = tmr_load_val(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] LAT_LOAD = tmr_load_val(READ_LATENCY);

   state_e            state_q;
   state_e            state_d;
   logic [31:0]       id_q;
   logic [31:0]       id_d;
   logic [31:0]       ts_q;
   logic [31:0]       ts_d;
   logic              pass_q;
   logic              pass_d;
   logic              timeout_q;
   logic              timeout_d;

   logic              tmr_load;
   logic [TMR_W-1:0]  tmr_load_val_s;
   logic              tmr_en;
   logic              tmr_zero;

   nios_fprint_rd_timer #(
      .W (TMR_W)
   ) u_rd_timer (
      .clk_i      (clock),
      .rst_i      (reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val_s),
      .en_i       (tmr_en),
      .zero_o     (tmr_zero)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         id_q      <= '0;
         ts_q      <= '0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         ts_q      <= ts_d;
         pass_q    <= pass_d;
         timeout_q <= timeout_d;
      end
   end

   // The timer is reused: armed with the stall budget in REQ_*, with the
   // read latency in LAT_*.
   always_comb begin
      state_d        = state_q;
      id_d           = id_q;
      ts_d           = ts_q;
      pass_d         = pass_q;
      timeout_d      = timeout_q;
      tmr_load       = 1'b0;
      tmr_load_val_s = TO_LOAD;
      tmr_en         = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_REQ_ID;
               pass_d    = 1'b0;
               timeout_d = 1'b0;
               tmr_load  = 1'b1;
            end
         end
         ST_REQ_ID: begin
            if (!waitrequest) begin
               tmr_load = 1'b1;
               if (READ_LATENCY == 0) begin
                  id_d    = readdata;
                  state_d = ST_REQ_TS;
               end else begin
                  tmr_load_val_s = LAT_LOAD;
                  state_d        = ST_LAT_ID;
               end
            end else if (tmr_zero) begin
               timeout_d = 1'b1;
               state_d   = ST_FINISH;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_LAT_ID: begin
            if (tmr_zero) begin
               id_d     = readdata;
               state_d  = ST_REQ_TS;
               tmr_load = 1'b1;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_REQ_TS: begin
            if (!waitrequest) begin
               if (READ_LATENCY == 0) begin
                  ts_d    = readdata;
                  state_d = ST_FINISH;
               end else begin
                  tmr_load       = 1'b1;
                  tmr_load_val_s = LAT_LOAD;
                  state_d        = ST_LAT_TS;
               end
            end else if (tmr_zero) begin
               timeout_d = 1'b1;
               state_d   = ST_FINISH;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_LAT_TS: begin
            if (tmr_zero) begin
               ts_d    = readdata;
               state_d = ST_FINISH;
            end else begin
               tmr_en = 1'b1;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Verdict is latched on entry so it is already valid while done pulses.
      if ((state_d == ST_FINISH) && (state_q != ST_FINISH)) begin
         pass_d = (id_d == EXPECTED_ID) && (ts_d == EXPECTED_TS) && !timeout_d;
      end
   end

   always_comb begin
      read    = 1'b0;
      address = SYSID_ADDR_ID;
      done    = 1'b0;
      busy    = (state_q != ST_IDLE);
      case (state_q)
         ST_REQ_ID: begin
            read = 1'b1;
         end
         ST_REQ_TS: begin
            read    = 1'b1;
            address = SYSID_ADDR_TS;
         end
         ST_FINISH: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign pass     = pass_q;
   assign timeout  = timeout_q;
   assign id_value = id_q;
   assign ts_value = ts_q;

endmodule

// File: doc/nios_fprint_sysid_checker.md
Name: nios_fprint_sysid_checker

Overview:
- Avalon-MM read master that interrogates the system-ID control slave at power-up or on request.
- Reads word 0 (system ID) and word 1 (build timestamp), then compares both against build-time expected values.
- Reports pass/fail, the captured values, and a timeout flag to the fingerprinting control logic.
- Prevents the fingerprint cores from running against a mismatched FPGA image.

Parameters:
- EXPECTED_ID, 32'h0000_0000, expected system ID (word 0).
- EXPECTED_TS, 32'h539F_2976, expected build timestamp (word 1).
- READ_LATENCY, 0, cycles from read acceptance to valid readdata; legal range 0..3.
- TIMEOUT_CYCLES, 255, maximum consecutive waitrequest cycles before abort; 8-bit counter; legal range 1..255.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run a check.
- address  out  1  Avalon address (0 = ID, 1 = timestamp).
- read  out  1  Avalon read strobe.
- readdata  in  32  Avalon read data.
- waitrequest  in  1  Avalon waitrequest; tie to 0 for a zero-wait slave.
- busy  out  1  check in progress.
- done  out  1  one-cycle pulse when a check completes or aborts.
- pass  out  1  sticky: last check matched both words.
- timeout  out  1  sticky: last check aborted on waitrequest.
- id_value  out  32  captured word 0.
- ts_value  out  32  captured word 1.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0. Reset mid-check drops read in the next cycle and discards the check; no done pulse.
- FSM states: IDLE, REQ_ID, LAT_ID, REQ_TS, LAT_TS, FINISH.
- IDLE:
  - On start, go to REQ_ID.
  - Clear pass and timeout; id_value and ts_value are not cleared.
  - start is ignored outside IDLE, including while done is pulsing.
- REQ_ID:
  - Drive read=1, address=0.
  - The transfer is accepted in a cycle with read && !waitrequest.
  - On acceptance with READ_LATENCY=0, capture readdata that cycle and go to REQ_TS.
  - On acceptance with READ_LATENCY>0, go to LAT_ID.
- LAT_ID:
  - Drive read=0.
  - Count READ_LATENCY cycles after acceptance; capture readdata on the READ_LATENCY-th cycle, then go to REQ_TS.
- REQ_TS / LAT_TS: same as REQ_ID / LAT_ID with address=1; the captured value goes to ts_value, then to FINISH.
- Back-to-back reads: with READ_LATENCY=0 and no waitrequest, read stays high for exactly 2 consecutive cycles, address 0 then 1.
- Timeout:
  - Counter increments each REQ_* cycle with waitrequest=1 and clears on acceptance.
  - When the count reaches TIMEOUT_CYCLES while still waiting: set timeout=1, pass=0, deassert read, go to FINISH.
  - The count restarts for the second read.
- FINISH:
  - pass = (id_value==EXPECTED_ID) && (ts_value==EXPECTED_TS) && !timeout.
  - Pulse done for one cycle, then go to IDLE.
- busy = 1 in every state except IDLE.
- Total latency (no waitrequest): start at cycle 0 gives done at cycle 3+2*READ_LATENCY.
- address is held stable while read=1 and waitrequest=1; readdata is ignored outside its capture cycle.

Decomposition:
- Shared package nios_fprint_pkg holds:
  - state enum typedef;
  - SYSID_ADDR_ID=0 and SYSID_ADDR_TS=1;
  - default EXPECTED_ID and EXPECTED_TS constants.
- Natural sub-module: nios_fprint_rd_timer, a shared latency/timeout down-counter with load, enable and zero flag.
- FSM and capture registers stay in the top level.

Test Plan:
- Zero-wait slave returning 0 for word 0 and 32'h539F2976 for word 1, start at cycle 0: read high at cycles 1-2, done at cycle 3, pass=1, timeout=0.
- Slave returns 32'h539F2977 for word 1: done pulses, pass=0, ts_value=32'h539F2977, id_value=0.
- waitrequest held 5 cycles on each read: done at cycle 13; address stable during stalls; pass=1.
- waitrequest stuck high, TIMEOUT_CYCLES=4: read drops after 4 stalled cycles, timeout=1, pass=0, exactly one done pulse.
- READ_LATENCY=2, readdata valid only 2 cycles after acceptance (garbage otherwise): correct capture, done at cycle 7.
- Reset asserted during LAT_TS, or start pulsed while busy: after reset all outputs 0 and no done pulse; the mid-check start is ignored and only one check runs.
